simd_alu: RTL
=============

SIMD_ALU -- requirements
Module: simd_alu

Interface
REQ-001 Parameter N, default 32, lane width in bits (legal values 8..64, power of two).
REQ-002 Parameter LANES, default 4, number of independent lanes (1..16).
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  operation request present.
REQ-006 in_ready  output  1  block accepts a request this cycle.
REQ-007 op  input  4  opcode: 0000 NOP, 0001 SUB, 0010 MUL, 0011 DIV, 0100 AND, 0101 OR, 0110 SRL, 0111 SLL, 1000 ADD, 1001 XOR.
REQ-008 lane_mask  input  LANES  per-lane enable; bit i governs lane i.
REQ-009 a, b  input  LANES*N  packed operands; lane i occupies bits [i*N +: N].
REQ-010 out_valid  output  1  result held and valid.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 result  output  LANES*N  packed results, same lane packing as a and b.
REQ-013 nop_flag  output  1  the held result came from a NOP.
REQ-014 illegal_op  output  1  the held result came from an opcode 1010..1111.
REQ-015 div_zero  output  LANES  per-lane flag: a DIV with b lane == 0 in an enabled lane.

Function
REQ-016 A transfer occurs on a cycle where in_valid && in_ready; op, lane_mask, a and b are captured at that edge.
REQ-017 FSM states: IDLE, DIV, OUT.
REQ-018 IDLE: in_ready=1; on a non-DIV transfer go to OUT; on a DIV transfer go to DIV.
REQ-019 Non-DIV latency is 1 cycle: out_valid=1 on the cycle after the transfer.
REQ-020 DIV: restoring divide, one quotient bit per cycle per lane; exactly N cycles in DIV, then OUT; total latency N+1 cycles; in_ready=0 throughout DIV.
REQ-021 OUT: out_valid=1; result and flags hold stable until out_valid && out_ready.
REQ-022 OUT with out_ready=1: in_ready=1; a simultaneous transfer starts the new operation at the same edge (next state OUT or DIV); otherwise next state IDLE.
REQ-023 OUT with out_ready=0: in_ready=0, state held.
REQ-024 Arithmetic is modulo 2^N per lane, unsigned: SUB wraps (two's complement), MUL returns the low N bits, ADD discards carry.
REQ-025 SRL/SLL shift the a lane by the unsigned b lane; shift amount >= N yields 0.
REQ-026 DIV with b lane == 0: quotient all ones, div_zero bit set; other lanes are unaffected.
REQ-027 A lane with lane_mask bit 0 produces a zero result and a zero div_zero bit, for every opcode.
REQ-028 NOP: result all zero, nop_flag=1, 1-cycle latency.
REQ-029 Opcodes 1010..1111: result all zero, illegal_op=1, 1-cycle latency.
REQ-030 Exactly one of nop_flag and illegal_op, or neither, is set per result; flags are 0 whenever out_valid=0.

Reset
REQ-031 rst=1 at a clock edge forces state IDLE, out_valid=0, result=0, nop_flag=0, illegal_op=0, div_zero=0.
REQ-032 rst during DIV or OUT aborts the operation; no result is delivered afterwards.
REQ-033 in_ready=0 while rst=1; in_ready=1 on the first cycle after rst is deasserted.

Structure
REQ-034 Package simd_alu_pkg holds the opcode enum (4-bit), the FSM state enum, and constant OP_LAST_LEGAL=4'b1001.
REQ-035 Sub-module simd_alu_lane_div implements the per-lane iterative divider (start, N-cycle step, quotient, div_zero); simd_alu instantiates LANES copies via generate.
REQ-036 Non-DIV lane logic is inline in simd_alu; a single shared FSM drives all lanes.

Verification (N=32, LANES=4)
REQ-037 ADD, mask 1111, a lanes {FFFFFFFF,1,2,3}, b lanes {1,1,2,3} -> after 1 cycle result lanes {0,2,4,6}, nop_flag=0.
REQ-038 DIV, a lanes {100,7,9,0}, b lanes {7,0,3,5}, mask 1111 -> out_valid exactly 33 cycles after the transfer; result lanes {14,FFFFFFFF,3,0}; div_zero=0010.
REQ-039 SLL, a lanes all 1, b lanes {0,31,32,40}, mask 0111 -> result lanes {1,80000000,0,0}; lane 3 is 0 because it is masked.
REQ-040 Back-to-back: OUT with out_ready=1 and in_valid=1 (SUB, a lane 0=3, b lane 0=5) -> the new result is valid on the next cycle with lane 0=FFFFFFFE; no idle cycle.
REQ-041 Backpressure: out_ready=0 for 5 cycles -> result stable, in_ready=0; op 1100 then yields result 0 with illegal_op=1.
REQ-042 rst asserted on cycle 10 of a DIV -> out_valid=0 next cycle; no result delivered; a subsequent ADD completes normally.

Source files
------------

// File: rtl/simd_alu_pkg.sv
// Shared opcode/state types and constants for the SIMD ALU.
package simd_alu_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'b0000,
    OP_SUB = 4'b0001,
    OP_MUL = 4'b0010,
    OP_DIV = 4'b0011,
    OP_AND = 4'b0100,
    OP_OR  = 4'b0101,
    OP_SRL = 4'b0110,
    OP_SLL = 4'b0111,
    OP_ADD = 4'b1000,
    OP_XOR = 4'b1001
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  localparam logic [3:0] OP_LAST_LEGAL = 4'b1001;

  // Opcodes above the last defined one produce a zero result with illegal_op.
  function automatic logic is_illegal(input logic [3:0] op);
    return op > OP_LAST_LEGAL;
  endfunction

endpackage

// File: rtl/simd_alu_lane_div.sv
// One lane of the iterative restoring divider: the first quotient bit is
// produced at start, one more per step, N bits in total.
module simd_alu_lane_div
  import simd_alu_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic         step_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] quot_o,
  output logic         div_zero_o
);

  logic [N-1:0] rem_q, rem_d;
  logic [N-1:0] quo_q, quo_d;
  logic [N-1:0] dvs_q;
  logic         dz_q;

  logic [N-1:0] rem_src, quo_src, dvs_src;
  logic [N:0]   shifted;

  // One restoring step on either fresh operands (start) or the running state.
  always_comb begin
    rem_src = start_i ? '0  : rem_q;
    quo_src = start_i ? a_i : quo_q;
    dvs_src = start_i ? b_i : dvs_q;
    shifted = {rem_src, quo_src[N-1]};
    rem_d   = shifted[N-1:0];
    quo_d   = {quo_src[N-2:0], 1'b0};
    if (shifted >= {1'b0, dvs_src}) begin
      rem_d = shifted[N-1:0] - dvs_src;
      quo_d = {quo_src[N-2:0], 1'b1};
    end
  end

  // Divider state; a zero divisor naturally yields an all-ones quotient.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      dz_q  <= 1'b0;
    end else if (start_i || step_i) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      if (start_i) begin
        dvs_q <= b_i;
        dz_q  <= (b_i == '0);
      end
    end
  end

  assign quot_o     = quo_q;
  assign div_zero_o = dz_q;

endmodule

// File: rtl/simd_alu.sv
// Multi-lane unsigned SIMD ALU with a valid/ready handshake on both sides and
// an N-cycle iterative divide path shared under one control FSM.
module simd_alu
  import simd_alu_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned LANES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           op,
  input  logic [LANES-1:0]     lane_mask,
  input  logic [LANES*N-1:0]   a,
  input  logic [LANES*N-1:0]   b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*N-1:0]   result,
  output logic                 nop_flag,
  output logic                 illegal_op,
  output logic [LANES-1:0]     div_zero
);

  localparam int unsigned CW = $clog2(N);
  localparam int unsigned SW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rdy;
  logic          start_div, step_div, load_alu, load_div, clear_out;

  logic [LANES-1:0]   mask_q;
  logic               out_valid_q, nop_q, illegal_q;
  logic [LANES*N-1:0] result_q;
  logic [LANES-1:0]   dz_q;

  logic [LANES*N-1:0] alu_res;
  logic [LANES*N-1:0] div_quot, div_res;
  logic [LANES-1:0]   div_dz_raw, div_dz;

  // State and divide-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, handshake and datapath load strobes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdy       = 1'b0;
    start_div = 1'b0;
    step_div  = 1'b0;
    load_alu  = 1'b0;
    load_div  = 1'b0;
    clear_out = 1'b0;
    case (state_q)
      ST_IDLE: rdy = 1'b1;
      ST_DIV: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d  = ST_OUT;
          load_div = 1'b1;
        end else begin
          step_div = 1'b1;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          rdy       = 1'b1;
          clear_out = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready = rdy && !rst;
    if (in_ready && in_valid) begin
      if (op == OP_DIV) begin
        state_d   = ST_DIV;
        cnt_d     = '0;
        start_div = 1'b1;
      end else begin
        state_d  = ST_OUT;
        load_alu = 1'b1;
      end
    end
  end

  // Single-cycle lane operations on the incoming operands.
  always_comb begin
    alu_res = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      logic [N-1:0] la, lb, r;
      la = a[i*N +: N];
      lb = b[i*N +: N];
      r  = '0;
      case (op)
        OP_SUB: r = la - lb;
        OP_MUL: r = la * lb;
        OP_AND: r = la & lb;
        OP_OR:  r = la | lb;
        OP_SRL: r = (lb >= N'(N)) ? '0 : (la >> lb[SW-1:0]);
        OP_SLL: r = (lb >= N'(N)) ? '0 : (la << lb[SW-1:0]);
        OP_ADD: r = la + lb;
        OP_XOR: r = la ^ lb;
        default: r = '0;
      endcase
      if (!lane_mask[i]) r = '0;
      alu_res[i*N +: N] = r;
    end
  end

  // Lane mask of the divide in flight.
  always_ff @(posedge clk) begin
    if (rst)            mask_q <= '0;
    else if (start_div) mask_q <= lane_mask;
  end

  for (genvar g = 0; g < int'(LANES); g++) begin : g_div
    simd_alu_lane_div #(.N(N)) u_div (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_div),
      .step_i     (step_div),
      .a_i        (a[g*N +: N]),
      .b_i        (b[g*N +: N]),
      .quot_o     (div_quot[g*N +: N]),
      .div_zero_o (div_dz_raw[g])
    );
  end

  // Masked divider outputs.
  always_comb begin
    div_res = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      div_res[i*N +: N] = mask_q[i] ? div_quot[i*N +: N] : '0;
    end
    div_dz = div_dz_raw & mask_q;
  end

  // Held result and flags, cleared when consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      nop_q       <= 1'b0;
      illegal_q   <= 1'b0;
      dz_q        <= '0;
    end else if (load_alu) begin
      out_valid_q <= 1'b1;
      result_q    <= alu_res;
      nop_q       <= (op == OP_NOP);
      illegal_q   <= is_illegal(op);
      dz_q        <= '0;
    end else if (load_div) begin
      out_valid_q <= 1'b1;
      result_q    <= div_res;
      nop_q       <= 1'b0;
      illegal_q   <= 1'b0;
      dz_q        <= div_dz;
    end else if (clear_out) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      nop_q       <= 1'b0;
      illegal_q   <= 1'b0;
      dz_q        <= '0;
    end
  end

  assign out_valid  = out_valid_q;
  assign result     = result_q;
  assign nop_flag   = nop_q;
  assign illegal_op = illegal_q;
  assign div_zero   = dz_q;

endmodule
